// File: rtl/nabp_filtered_line_reader.sv
// Requests an angle from swap control, sweeps s=0..N-1 through the filtered RAM bank and streams (angle,s,val).
// First tuple kReadLatency+1 cycles after sweep start; reads stall on out_ready low, the small output FIFO never overflows.
module nabp_filtered_line_reader #(
    parameter int kAngleLength        = 9,
    parameter int kSLength            = 9,
    parameter int kFilteredDataLength = 16,
    parameter int kProjectionLineSize = 256,
    parameter int kReadLatency        = 1,
    parameter int kFifoDepth          = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    output logic                           pr_next_angle,
    input  logic                           pr_next_angle_ack,
    input  logic [kAngleLength-1:0]        pr_angle,
    input  logic                           pr_has_next_angle,
    output logic [kSLength-1:0]            pr_s_val,
    input  logic [kFilteredDataLength-1:0] pr_val,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [kAngleLength-1:0]        out_angle,
    output logic [kSLength-1:0]            out_s,
    output logic [kFilteredDataLength-1:0] out_val,
    output logic                           out_last,
    output logic                           done
);

    localparam int CW = $clog2(kFifoDepth + kReadLatency + 2);
    localparam int PW = (kFifoDepth > 1) ? $clog2(kFifoDepth) : 1;
    localparam logic [kSLength-1:0] kLastS = kSLength'(kProjectionLineSize - 1);
    localparam logic [PW-1:0]       kLastPtr = PW'(kFifoDepth - 1);

    typedef enum logic [2:0] {REQ, ACK_LOW, SWEEP, DRAIN, DONE_ST} state_t;

    typedef struct packed {
        logic [kAngleLength-1:0]        angle;
        logic [kSLength-1:0]            s;
        logic [kFilteredDataLength-1:0] val;
        logic                           last;
    } entry_t;

    state_t                  state_q, state_d;
    logic                    req_q, req_d;
    logic [kAngleLength-1:0] angle_q;
    logic                    has_next_q;
    logic [kSLength-1:0]     s_q;
    logic [kSLength-1:0]     s_hold_q;

    logic                    tag_vld_q  [kReadLatency];
    logic [kSLength-1:0]     tag_s_q    [kReadLatency];
    logic                    tag_last_q [kReadLatency];

    entry_t                  mem_q [kFifoDepth];
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           count_q;
    logic [CW-1:0]           inflight;
    logic [CW-1:0]           occ;

    logic                    take_ack;
    logic                    issue;
    logic                    push;
    logic                    pop;
    entry_t                  head;

    assign take_ack = (state_q == REQ) && req_q && pr_next_angle_ack;
    assign push     = tag_vld_q[kReadLatency-1];
    assign out_valid = (count_q != '0);
    assign pop      = out_valid && out_ready;
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < kReadLatency; i++) begin
            inflight = inflight + CW'(tag_vld_q[i]);
        end
    end

    // A slot being popped this cycle is free for the read issued this cycle.
    assign occ   = count_q + inflight;
    assign issue = (state_q == SWEEP) && (occ < (CW'(kFifoDepth) + CW'(pop)));

    assign pr_s_val      = issue ? s_q : s_hold_q;
    assign pr_next_angle = req_q;
    assign out_angle     = head.angle;
    assign out_s         = head.s;
    assign out_val       = head.val;
    assign out_last      = head.last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            REQ:     if (take_ack) state_d = ACK_LOW;
            ACK_LOW: if (!pr_next_angle_ack) state_d = SWEEP;
            SWEEP:   if (issue && (s_q == kLastS)) state_d = DRAIN;
            // Bank data is only valid until the next swap request, so drain fully first.
            DRAIN:   if ((count_q == '0) && (inflight == '0)) state_d = has_next_q ? REQ : DONE_ST;
            DONE_ST: state_d = DONE_ST;
            default: state_d = REQ;
        endcase
    end

    always_comb begin
        req_d = (state_d == REQ);
        done  = (state_q == DONE_ST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q      <= 1'b0;
            angle_q    <= '0;
            has_next_q <= 1'b1;
            s_q        <= '0;
            s_hold_q   <= '0;
        end else begin
            req_q <= req_d;
            if (take_ack) begin
                angle_q    <= pr_angle;
                has_next_q <= pr_has_next_angle;
            end
            if (issue) begin
                s_q      <= s_q + kSLength'(1);
                s_hold_q <= s_q;
            end else if (state_q != SWEEP) begin
                s_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < kReadLatency; i++) begin
                tag_vld_q[i]  <= 1'b0;
                tag_s_q[i]    <= '0;
                tag_last_q[i] <= 1'b0;
            end
        end else begin
            tag_vld_q[0]  <= issue;
            tag_s_q[0]    <= s_q;
            tag_last_q[0] <= (s_q == kLastS);
            for (int i = 1; i < kReadLatency; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_s_q[i]    <= tag_s_q[i-1];
                tag_last_q[i] <= tag_last_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < kFifoDepth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{angle: angle_q,
                                     s:     tag_s_q[kReadLatency-1],
                                     val:   pr_val,
                                     last:  tag_last_q[kReadLatency-1]};
                wr_ptr_q <= (wr_ptr_q == kLastPtr) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == kLastPtr) ? '0 : rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop && (count_q == CW'(kFifoDepth))));

endmodule

// File: tb/tb_nabp_filtered_line_reader.sv
// Directed bench for nabp_filtered_line_reader with N=8, a 1-cycle RAM model and a scripted swap control.
module tb_nabp_filtered_line_reader;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pr_next_angle, pr_next_angle_ack, pr_has_next_angle;
    logic [8:0]  pr_angle, pr_s_val, out_angle, out_s;
    logic [15:0] pr_val, out_val;
    logic        out_valid, out_ready, out_last, done;

    logic [8:0]  bank_angle = '0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          ack_cyc = 0;
    int          req_rises = 0;
    logic        req_prev = 1'b0;
    logic        tog_en = 1'b0;

    logic [8:0]  qa[$];
    logic [8:0]  qs[$];
    logic [15:0] qv[$];
    logic        ql[$];
    int          qc[$];

    always #5 clk = ~clk;

    nabp_filtered_line_reader #(.kProjectionLineSize(N)) dut (
        .clk(clk), .reset_n(reset_n),
        .pr_next_angle(pr_next_angle), .pr_next_angle_ack(pr_next_angle_ack),
        .pr_angle(pr_angle), .pr_has_next_angle(pr_has_next_angle),
        .pr_s_val(pr_s_val), .pr_val(pr_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_angle(out_angle), .out_s(out_s), .out_val(out_val),
        .out_last(out_last), .done(done)
    );

    // Filtered RAM bank model: sample = s + angle of the swapped-in bank, one cycle read latency.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        pr_val <= 16'(pr_s_val) + 16'(bank_angle);
    end

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            qa.push_back(out_angle); qs.push_back(out_s); qv.push_back(out_val);
            ql.push_back(out_last);  qc.push_back(cyc);
        end
        if (pr_next_angle && !req_prev) req_rises++;
        req_prev = pr_next_angle;
    end

    task automatic clear_q();
        qa.delete(); qs.delete(); qv.delete(); ql.delete(); qc.delete();
        req_rises = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; pr_next_angle_ack = 1'b0; pr_angle = '0; pr_has_next_angle = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        clear_q();
    endtask

    task automatic serve(input logic [8:0] a, input logic hn, input int hold);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (pr_next_angle) break;
        end
        n_chk++;
        if (pr_next_angle !== 1'b1) $display("FAIL serve_req(%0d): pr_next_angle=%b required 1", a, pr_next_angle);
        else n_pass++;
        @(posedge clk); #1;
        pr_next_angle_ack = 1'b1; pr_angle = a; pr_has_next_angle = hn; bank_angle = a; ack_cyc = cyc;
        repeat (hold) @(posedge clk);
        #1 pr_next_angle_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        pr_next_angle_ack = 1'b0; pr_angle = '0; pr_has_next_angle = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({pr_next_angle, pr_s_val, out_valid, out_angle, out_s, out_val, out_last, done} !== '0)
            $display("FAIL reset_outputs: got req=%b s_val=%0d vld=%b ang=%0d s=%0d val=%0d last=%b done=%b required all 0",
                     pr_next_angle, pr_s_val, out_valid, out_angle, out_s, out_val, out_last, done);
        else n_pass++;
        @(posedge clk); #1 reset_n = 1'b1;
        clear_q();
        @(negedge clk);
        n_chk++;
        if (pr_next_angle !== 1'b0) $display("FAIL reset_req_reg: got %b required 0", pr_next_angle); else n_pass++;
        @(negedge clk);
        n_chk++;
        if (pr_next_angle !== 1'b1) $display("FAIL reset_req_rise: got %b required 1", pr_next_angle); else n_pass++;
    endtask

    task automatic test_single_line();
        do_reset();
        serve(9'd20, 1'b1, 1);
        for (int k = 0; k < 100 && qs.size() < N; k++) @(negedge clk);
        n_chk++;
        if (qs.size() != N) $display("FAIL line_count: got %0d required %0d", qs.size(), N); else n_pass++;
        for (int i = 0; i < N; i++) begin
            if (i < qs.size()) begin
                n_chk++;
                if ({qa[i], qs[i], qv[i], ql[i]} !== {9'd20, 9'(i), 16'(20 + i), (i == N - 1)})
                    $display("FAIL line_tuple[%0d]: got (%0d,%0d,%0d,%b) required (20,%0d,%0d,%b)",
                             i, qa[i], qs[i], qv[i], ql[i], i, 20 + i, (i == N - 1));
                else n_pass++;
            end
        end
        if (qs.size() == N) begin
            n_chk++;
            if (qc[0] !== ack_cyc + 4) $display("FAIL line_latency: first at cycle %0d required %0d", qc[0], ack_cyc + 4);
            else n_pass++;
            n_chk++;
            if (qc[N-1] - qc[0] !== N - 1) $display("FAIL line_bubbles: span %0d required %0d", qc[N-1] - qc[0], N - 1);
            else n_pass++;
        end
        for (int k = 0; k < 50 && !pr_next_angle; k++) @(negedge clk);
        n_chk++;
        if (pr_next_angle !== 1'b1) $display("FAIL line_rerequest: got %b required 1", pr_next_angle); else n_pass++;
    endtask

    task automatic test_ack_hold();
        do_reset();
        for (int k = 0; k < 50 && !pr_next_angle; k++) @(negedge clk);
        @(posedge clk); #1;
        pr_next_angle_ack = 1'b1; pr_angle = 9'd33; pr_has_next_angle = 1'b1; bank_angle = 9'd33;
        @(posedge clk); #1 pr_angle = 9'd99;
        @(negedge clk);
        n_chk++;
        if (pr_next_angle !== 1'b0) $display("FAIL ackhold_drop: got %b required 0", pr_next_angle); else n_pass++;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({out_valid, pr_next_angle, 32'(qs.size())} !== 34'd0)
            $display("FAIL ackhold_no_sweep: vld=%b req=%b tuples=%0d required 0,0,0", out_valid, pr_next_angle, qs.size());
        else n_pass++;
        @(posedge clk); #1 pr_next_angle_ack = 1'b0;
        for (int k = 0; k < 100 && qs.size() < N; k++) @(negedge clk);
        n_chk++;
        if (qs.size() != N) $display("FAIL ackhold_count: got %0d required %0d", qs.size(), N); else n_pass++;
        for (int i = 0; i < N; i++) begin
            if (i < qs.size()) begin
                n_chk++;
                if ({qa[i], qs[i], qv[i]} !== {9'd33, 9'(i), 16'(33 + i)})
                    $display("FAIL ackhold_tuple[%0d]: got (%0d,%0d,%0d) required (33,%0d,%0d)", i, qa[i], qs[i], qv[i], i, 33 + i);
                else n_pass++;
            end
        end
    endtask

    task automatic test_multi_angle();
        int done_cyc;
        int nlast;
        do_reset();
        for (int a = 0; a < 5; a++) serve(9'(a * 20), (a != 4), 1);
        done_cyc = -1;
        for (int k = 0; k < 200 && !done; k++) @(negedge clk);
        done_cyc = cyc;
        n_chk++;
        if (done !== 1'b1) $display("FAIL multi_done: got %b required 1", done); else n_pass++;
        n_chk++;
        if (qs.size() != 5 * N) $display("FAIL multi_count: got %0d required %0d", qs.size(), 5 * N); else n_pass++;
        nlast = 0;
        for (int j = 0; j < 5 * N; j++) begin
            if (j < qs.size()) begin
                nlast += int'(ql[j]);
                n_chk++;
                if ({qa[j], qs[j], qv[j], ql[j]} !== {9'((j / N) * 20), 9'(j % N), 16'((j / N) * 20 + j % N), (j % N == N - 1)})
                    $display("FAIL multi_tuple[%0d]: got (%0d,%0d,%0d,%b) required (%0d,%0d,%0d,%b)", j, qa[j], qs[j], qv[j], ql[j],
                             (j / N) * 20, j % N, (j / N) * 20 + j % N, (j % N == N - 1));
                else n_pass++;
            end
        end
        n_chk++;
        if (nlast != 5) $display("FAIL multi_last_count: got %0d required 5", nlast); else n_pass++;
        if (qs.size() == 5 * N) begin
            n_chk++;
            if (done_cyc <= qc[5*N-1]) $display("FAIL multi_done_early: done at %0d, last offered at %0d", done_cyc, qc[5*N-1]);
            else n_pass++;
        end
        repeat (20) @(negedge clk);
        n_chk++;
        if ({req_rises, pr_next_angle, done} !== {32'd5, 1'b0, 1'b1})
            $display("FAIL multi_no_sixth: rises=%0d req=%b done=%b required 5,0,1", req_rises, pr_next_angle, done);
        else n_pass++;
    endtask

    task automatic test_backpressure_toggle();
        logic        prev_stall;
        logic [34:0] snap;
        int          nstall;
        do_reset();
        tog_en = 1'b1; prev_stall = 1'b0; snap = '0; nstall = 0;
        fork
            begin
                serve(9'd40, 1'b1, 1);
                for (int k = 0; k < 300 && qs.size() < N; k++) begin
                    @(negedge clk);
                    if (prev_stall) begin
                        nstall++;
                        n_chk++;
                        if ({out_valid, out_angle, out_s, out_val, out_last} !== {1'b1, snap[34:1], snap[0]})
                            $display("FAIL bp_stable: got (%b,%0d,%0d,%0d,%b) required (1,%0d,%0d,%0d,%b)", out_valid,
                                     out_angle, out_s, out_val, out_last, snap[34:26], snap[25:17], snap[16:1], snap[0]);
                        else n_pass++;
                    end
                    prev_stall = out_valid && !out_ready;
                    snap = {out_angle, out_s, out_val, out_last};
                end
                tog_en = 1'b0;
            end
            begin
                int k = 0;
                while (tog_en) begin
                    @(posedge clk); #1;
                    out_ready = ((k % 4) == 0) || ((k % 4) == 3);
                    k++;
                end
            end
        join
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        n_chk++;
        if (qs.size() != N) $display("FAIL bp_count: got %0d required %0d", qs.size(), N); else n_pass++;
        n_chk++;
        if (nstall == 0) $display("FAIL bp_stall_seen: got %0d stalls required >0", nstall); else n_pass++;
        for (int i = 0; i < N; i++) begin
            if (i < qs.size()) begin
                n_chk++;
                if ({qa[i], qs[i], qv[i], ql[i]} !== {9'd40, 9'(i), 16'(40 + i), (i == N - 1)})
                    $display("FAIL bp_tuple[%0d]: got (%0d,%0d,%0d,%b) required (40,%0d,%0d,%b)",
                             i, qa[i], qs[i], qv[i], ql[i], i, 40 + i, (i == N - 1));
                else n_pass++;
            end
        end
    endtask

    task automatic test_ready_low();
        do_reset();
        out_ready = 1'b0;
        serve(9'd20, 1'b1, 1);
        repeat (30) @(negedge clk);
        n_chk++;
        if ({out_valid, pr_s_val, pr_next_angle, out_s, out_val} !== {1'b1, 9'd1, 1'b0, 9'd0, 16'd20})
            $display("FAIL rdylow_stall: vld=%b s_val=%0d req=%b head_s=%0d head_val=%0d required 1,1,0,0,20",
                     out_valid, pr_s_val, pr_next_angle, out_s, out_val);
        else n_pass++;
        @(posedge clk); #1 out_ready = 1'b1;
        for (int k = 0; k < 100 && qs.size() < N; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_chk++;
        if (qs.size() != N) $display("FAIL rdylow_count: got %0d required %0d", qs.size(), N); else n_pass++;
        for (int i = 0; i < N; i++) begin
            if (i < qs.size()) begin
                n_chk++;
                if ({qa[i], qs[i], qv[i], ql[i]} !== {9'd20, 9'(i), 16'(20 + i), (i == N - 1)})
                    $display("FAIL rdylow_tuple[%0d]: got (%0d,%0d,%0d,%b) required (20,%0d,%0d,%b)",
                             i, qa[i], qs[i], qv[i], ql[i], i, 20 + i, (i == N - 1));
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        do_reset();
        serve(9'd40, 1'b1, 1);
        for (int k = 0; k < 100 && !(out_valid && out_s == 9'd3); k++) @(negedge clk);
        n_chk++;
        if (out_s !== 9'd3) $display("FAIL midrst_reach_s3: got %0d required 3", out_s); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_chk++;
        if ({pr_next_angle, pr_s_val, out_valid, out_angle, out_s, out_val, out_last, done} !== '0)
            $display("FAIL midrst_async: got req=%b s_val=%0d vld=%b ang=%0d s=%0d val=%0d last=%b done=%b required all 0",
                     pr_next_angle, pr_s_val, out_valid, out_angle, out_s, out_val, out_last, done);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        clear_q();
        serve(9'd60, 1'b1, 1);
        for (int k = 0; k < 100 && qs.size() < N; k++) @(negedge clk);
        n_chk++;
        if (qs.size() != N) $display("FAIL midrst_count: got %0d required %0d", qs.size(), N); else n_pass++;
        if (qs.size() == N) begin
            n_chk++;
            if (qc[0] !== ack_cyc + 4) $display("FAIL midrst_latency: first at %0d required %0d", qc[0], ack_cyc + 4);
            else n_pass++;
        end
        for (int i = 0; i < N; i++) begin
            if (i < qs.size()) begin
                n_chk++;
                if ({qa[i], qs[i], qv[i], ql[i]} !== {9'd60, 9'(i), 16'(60 + i), (i == N - 1)})
                    $display("FAIL midrst_tuple[%0d]: got (%0d,%0d,%0d,%b) required (60,%0d,%0d,%b)",
                             i, qa[i], qs[i], qv[i], ql[i], i, 60 + i, (i == N - 1));
                else n_pass++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_line();
        test_ack_hold();
        test_multi_angle();
        test_backpressure_toggle();
        test_ready_low();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/nabp_filtered_line_reader.md
Name: nabp_filtered_line_reader

Overview:
- Processing-side consumer of the filtered RAM swap control.
- Requests an angle with the pr_next_angle / pr_next_angle_ack handshake, then sweeps s addresses 0..kProjectionLineSize-1 into the swapped-in filtered RAM bank.
- Captures the read data after the RAM latency and streams (angle, s, value) tuples to the backprojection datapath over a valid/ready interface with backpressure.

Parameters:
kAngleLength, 9, width of angle
kSLength, 9, width of s address
kFilteredDataLength, 16, width of filtered sample (signed)
kProjectionLineSize, 256, samples per projection line (s range 0..N-1)
kReadLatency, 1, cycles from pr_s_val to valid pr_val
kFifoDepth, 2, output buffer entries (>= kReadLatency+1)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
pr_next_angle  out  1  request next angle from swap control
pr_next_angle_ack  in  1  swap control ack; pr_angle valid while high
pr_angle  in  kAngleLength  angle of swapped-in bank
pr_has_next_angle  in  1  sampled with ack; 0 = this is the final angle
pr_s_val  out  kSLength  read address into filtered RAM bank
pr_val  in  kFilteredDataLength  read data, kReadLatency after pr_s_val
out_valid  out  1  output tuple valid
out_ready  in  1  downstream accepts when out_valid & out_ready
out_angle  out  kAngleLength  angle of tuple
out_s  out  kSLength  s of tuple
out_val  out  kFilteredDataLength  filtered sample
out_last  out  1  tuple is s = N-1 of its angle
done  out  1  sticky; final angle fully drained

Behaviour:
- Reset (async, reset_n low): state REQ, pr_next_angle=0, pr_s_val=0, out_valid=0, out_last=0, out_angle/out_s/out_val=0, done=0, FIFO empty, in-flight count 0, latched angle 0, latched has_next 1.
- pr_next_angle is registered.
- REQ: drive pr_next_angle=1. When pr_next_angle_ack is sampled high:
  - latch pr_angle and pr_has_next_angle;
  - drop pr_next_angle the next cycle;
  - go to ACK_LOW.
- ACK_LOW: wait for pr_next_angle_ack to be sampled low, then SWEEP with s=0.
  - Ack is level-based. Never re-request while ack is still high.
- SWEEP issues one read per cycle when (fifo_count + inflight) < kFifoDepth, counting an entry popped this cycle as free:
  - pr_s_val = s, tag (s, last = s==N-1) enters a kReadLatency-deep shift pipeline;
  - s increments. After issuing s=N-1, go to DRAIN. pr_s_val holds its last value when not issuing.
- Data capture: a tag emerging from the pipeline pushes {latched angle, tag s, pr_val, tag last} into the FIFO in that cycle. Overflow is impossible by construction; an assertion checks it.
- Output: out_* shows the FIFO head; out_valid = FIFO non-empty. Pop on out_valid & out_ready. Simultaneous push and pop on a full FIFO is legal.
- Full throughput: with out_ready held high, one tuple per cycle, no bubbles inside a line. First tuple appears kReadLatency+1 cycles after SWEEP entry.
- out_ready low: issue stalls within kFifoDepth-kReadLatency cycles. No tuple is lost or duplicated; out_* are stable while out_valid & !out_ready.
- DRAIN: wait until the pipeline and FIFO are empty, because bank data becomes invalid once the next swap is requested. Then:
  - latched has_next=1 -> REQ;
  - latched has_next=0 -> DONE.
- DONE: done=1, pr_next_angle=0, idle until reset.
- Ack arriving while not in REQ is ignored. An angle of 0 is legal.
- s counter width is kSLength. The N-1 compare is exact, so there is no wrap and no s=N issue.
- Reset mid-sweep: all state, FIFO and pipeline are discarded immediately; the sequence restarts from REQ.

Test Plan:
- N=8, latency 1, ready=1, swap control acks angle 20 with has_next=1 and pr_val=s+angle -> out tuples (20,0,20)..(20,7,27) on 8 consecutive cycles, out_last only on s=7, then pr_next_angle re-rises.
- Angles 0,20,40,60,80 with has_next=0 on 80 -> 40 tuples, out_last 5 times, done=1 after (80,7,87) is accepted, no sixth request.
- out_ready toggling 1,0,0,1 repeating during angle 40 -> all values 40..47 delivered exactly once, in order, out_* stable during stalls.
- Ack held high 5 cycles -> single latch of pr_angle, pr_next_angle low after 1 cycle, SWEEP starts only after ack is low.
- out_ready=0 throughout angle 20 -> at most kFifoDepth reads issued, FIFO full, no overflow assertion, no re-request. Releasing ready drains 8 tuples.
- reset_n pulsed low at s=3 of angle 40 -> outputs at reset values asynchronously; after release, pr_next_angle=1 and a fresh sweep from s=0.
